// File: rtl/pc_source_unit_if.sv
// Bus between the control unit/datapath and the PC source unit: candidate
// targets and update controls in, PC/EPC state and status pulses out.
interface pc_source_unit_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3
);
  logic [NUM_SRC*WIDTH-1:0] src_bus;
  logic [SEL_W-1:0]         pc_sel;
  logic                     pc_write;
  logic                     pc_write_cond;
  logic                     cond;
  logic                     exc_req;
  logic                     eret;
  logic [WIDTH-1:0]         pc;
  logic [WIDTH-1:0]         epc;
  logic [WIDTH-1:0]         next_pc;
  logic                     in_exc;
  logic                     sel_err;
  logic                     misalign;

  modport master (
    output src_bus, pc_sel, pc_write, pc_write_cond, cond, exc_req, eret,
    input  pc, epc, next_pc, in_exc, sel_err, misalign
  );

  modport slave (
    input  src_bus, pc_sel, pc_write, pc_write_cond, cond, exc_req, eret,
    output pc, epc, next_pc, in_exc, sel_err, misalign
  );
endinterface

// File: rtl/pc_source_unit.sv
// Next-PC source select with PC/EPC ownership, update gating, bad-select and
// misaligned-target detection, and a RUN/VECTOR/EXC exception-entry FSM.
module pc_source_unit #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_SRC     = 5,
  parameter int               SEL_W       = 3,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR  = 'hFF,
  parameter int               PC_STEP     = 4,
  parameter int               ALIGN_CHECK = 1
) (
  input  logic               clk,
  input  logic               reset,
  pc_source_unit_if.slave    bus
);

  typedef enum logic [1:0] {RUN, VECTOR, EXC} state_t;

  state_t                          state, state_n;
  logic [WIDTH-1:0]                pc_q, pc_n, epc_q, epc_n, next_pc;
  logic                            in_exc_q, in_exc_n;
  logic                            sel_err_q, sel_err_n, misalign_q, misalign_n;
  logic [NUM_SRC-1:0][WIDTH-1:0]   src;
  logic                            upd, sel_bad, mis;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign src[k] = bus.src_bus[k*WIDTH +: WIDTH];
  end

  // Out-of-range selects fall back to the current PC so next_pc is always defined.
  always_comb begin
    next_pc = pc_q;
    for (int k = 0; k < NUM_SRC; k++)
      if (bus.pc_sel == SEL_W'(k)) next_pc = src[k];
  end

  assign sel_bad = {1'b0, bus.pc_sel} >= (SEL_W+1)'(NUM_SRC);
  assign mis     = (ALIGN_CHECK != 0) && (next_pc[1:0] != 2'b00);
  assign upd     = bus.pc_write | (bus.pc_write_cond & bus.cond);

  always_comb begin
    state_n    = state;
    pc_n       = pc_q;
    epc_n      = epc_q;
    in_exc_n   = in_exc_q;
    sel_err_n  = 1'b0;
    misalign_n = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.exc_req) begin
          epc_n   = pc_q - WIDTH'(PC_STEP);
          state_n = VECTOR;
        end else if (upd && sel_bad) begin
          sel_err_n = 1'b1;
        end else if (upd && mis) begin
          misalign_n = 1'b1;
          epc_n      = next_pc;
          state_n    = VECTOR;
        end else if (upd) begin
          pc_n = next_pc;
        end
      end
      VECTOR: begin
        pc_n     = EXC_VECTOR;
        in_exc_n = 1'b1;
        state_n  = EXC;
      end
      EXC: begin
        // Nested faults re-vector but keep the EPC of the original fault.
        if (bus.eret) begin
          pc_n     = epc_q;
          in_exc_n = 1'b0;
          state_n  = RUN;
        end else if (bus.exc_req) begin
          state_n = VECTOR;
        end else if (upd && sel_bad) begin
          sel_err_n = 1'b1;
        end else if (upd && mis) begin
          misalign_n = 1'b1;
          state_n    = VECTOR;
        end else if (upd) begin
          pc_n = next_pc;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      in_exc_q   <= 1'b0;
      sel_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_n;
      pc_q       <= pc_n;
      epc_q      <= epc_n;
      in_exc_q   <= in_exc_n;
      sel_err_q  <= sel_err_n;
      misalign_q <= misalign_n;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.epc      = epc_q;
  assign bus.next_pc  = next_pc;
  assign bus.in_exc   = in_exc_q;
  assign bus.sel_err  = sel_err_q;
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_pc_source_unit.sv
// Scoreboard bench: the driver queues the expected register state for each
// cycle it drives, a negedge monitor pops and compares.
module tb_pc_source_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_source_unit_if #(.WIDTH(32), .NUM_SRC(5), .SEL_W(3)) pif ();

  pc_source_unit #(
    .WIDTH(32), .NUM_SRC(5), .SEL_W(3), .RESET_PC(32'h0), .EXC_VECTOR(32'hFF),
    .PC_STEP(4), .ALIGN_CHECK(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(pif.slave)
  );

  typedef struct {
    string       nm;
    logic [31:0] pc, epc, npc;
    logic        ie, se, ma, cn;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, ".pc"},       pif.pc,              e.pc);
      chk({e.nm, ".epc"},      pif.epc,             e.epc);
      chk({e.nm, ".in_exc"},   32'(pif.in_exc),     32'(e.ie));
      chk({e.nm, ".sel_err"},  32'(pif.sel_err),    32'(e.se));
      chk({e.nm, ".misalign"}, 32'(pif.misalign),   32'(e.ma));
      if (e.cn) chk({e.nm, ".next_pc"}, pif.next_pc, e.npc);
    end
  end

  // Drive one cycle of inputs and queue the state expected after its edge.
  task automatic cyc(input string nm, input logic wr, wc, cnd, input logic [2:0] sel,
                     input logic exc, er, input logic [31:0] pc_x, epc_x,
                     input logic ie, se, ma, input logic cn = 1'b0,
                     input logic [31:0] npc = 32'h0);
    exp_t e;
    @(negedge clk);
    #1;
    pif.pc_write = wr; pif.pc_write_cond = wc; pif.cond = cnd;
    pif.pc_sel = sel;  pif.exc_req = exc;      pif.eret = er;
    e.nm = nm; e.pc = pc_x; e.epc = epc_x; e.ie = ie; e.se = se; e.ma = ma;
    e.cn = cn; e.npc = npc;
    sb.push_back(e);
  endtask

  initial begin
    // src4..src0
    pif.src_bus = {32'h20, 32'h40, 32'h100, 32'h102, 32'h10};
    pif.pc_sel = 3'd0; pif.pc_write = 0; pif.pc_write_cond = 0;
    pif.cond = 0; pif.exc_req = 0; pif.eret = 0;
    #12;
    chk("reset.pc",     pif.pc,              32'h0);
    chk("reset.epc",    pif.epc,             32'h0);
    chk("reset.in_exc", 32'(pif.in_exc),     32'h0);
    chk("reset.pulses", 32'({pif.sel_err, pif.misalign}), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    //  name          wr wc c  sel exc er  pc        epc       ie se ma
    cyc("wr1",        1, 0, 0, 3,  0,  0, 32'h40,   32'h0,    0, 0, 0);
    cyc("wr2",        1, 0, 0, 3,  0,  0, 32'h40,   32'h0,    0, 0, 0);
    cyc("wr3",        1, 0, 0, 3,  0,  0, 32'h40,   32'h0,    0, 0, 0);
    cyc("cond0",      0, 1, 0, 2,  0,  0, 32'h40,   32'h0,    0, 0, 0);
    cyc("cond1",      0, 1, 1, 2,  0,  0, 32'h100,  32'h0,    0, 0, 0);
    cyc("to20",       1, 0, 0, 4,  0,  0, 32'h20,   32'h0,    0, 0, 0);
    cyc("exc",        1, 0, 0, 3,  1,  0, 32'h20,   32'h1C,   0, 0, 0);
    cyc("vector",     0, 0, 0, 0,  0,  0, 32'hFF,   32'h1C,   1, 0, 0);
    cyc("handler",    1, 0, 0, 0,  0,  0, 32'h10,   32'h1C,   1, 0, 0);
    cyc("eret",       1, 0, 0, 3,  0,  1, 32'h1C,   32'h1C,   0, 0, 0);
    cyc("misal",      1, 0, 0, 1,  0,  0, 32'h1C,   32'h102,  0, 0, 1);
    cyc("misal_vec",  0, 0, 0, 0,  0,  0, 32'hFF,   32'h102,  1, 0, 0);
    cyc("misal_eret", 0, 0, 0, 0,  0,  1, 32'h102,  32'h102,  0, 0, 0);
    cyc("fix40",      1, 0, 0, 3,  0,  0, 32'h40,   32'h102,  0, 0, 0);
    cyc("badsel",     1, 0, 0, 7,  0,  0, 32'h40,   32'h102,  0, 1, 0, 1, 32'h40);
    cyc("badsel_clr", 0, 0, 0, 7,  0,  0, 32'h40,   32'h102,  0, 0, 0, 1, 32'h40);
    cyc("eret_run",   0, 0, 0, 0,  0,  1, 32'h40,   32'h102,  0, 0, 0);
    cyc("exc2",       0, 0, 0, 0,  1,  0, 32'h40,   32'h3C,   0, 0, 0);
    cyc("exc2_vec",   0, 0, 0, 0,  0,  0, 32'hFF,   32'h3C,   1, 0, 0);
    cyc("exc2_hdl",   1, 0, 0, 0,  0,  0, 32'h10,   32'h3C,   1, 0, 0);
    cyc("nested",     0, 0, 0, 0,  1,  0, 32'h10,   32'h3C,   1, 0, 0);
    cyc("nested_vec", 0, 0, 0, 0,  0,  0, 32'hFF,   32'h3C,   1, 0, 0);
    cyc("in_exc",     0, 0, 0, 0,  0,  0, 32'hFF,   32'h3C,   1, 0, 0);

    // Async reset between edges while in EXC.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("areset.pc",     pif.pc,          32'h0);
    chk("areset.epc",    pif.epc,         32'h0);
    chk("areset.in_exc", 32'(pif.in_exc), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc("post_rst",   1, 0, 0, 3,  0,  0, 32'h40,   32'h0,    0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
